// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the requester, response and ALU-side signals of
// alu_arbiter.
//   slave  modport - the arbiter: takes requests and ALU results, drives
//                    ready, responses and ALU operands.
//   master modport - the environment: requesters, response consumers and
//                    the combinational ALU.
// Signal names keep their arbiter-relative _i/_o suffixes on both sides.
interface alu_arbiter_if #(
  parameter int unsigned DW = 32
);
  logic          req0_valid_i;
  logic          req0_ready_o;
  logic [DW-1:0] req0_op1_i;
  logic [DW-1:0] req0_op2_i;
  logic [2:0]    req0_ctrl_i;

  logic          req1_valid_i;
  logic          req1_ready_o;
  logic [DW-1:0] req1_op1_i;
  logic [DW-1:0] req1_op2_i;
  logic [2:0]    req1_ctrl_i;

  logic          rsp0_valid_o;
  logic          rsp0_ready_i;
  logic          rsp1_valid_o;
  logic          rsp1_ready_i;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_eq_o;

  logic [DW-1:0] alu_op1_o;
  logic [DW-1:0] alu_op2_o;
  logic [2:0]    alu_ctrl_o;
  logic [DW-1:0] alu_out_i;
  logic          alu_eq_i;

  modport slave (
    input  req0_valid_i, req0_op1_i, req0_op2_i, req0_ctrl_i,
    input  req1_valid_i, req1_op1_i, req1_op2_i, req1_ctrl_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp1_valid_o, rsp_data_o, rsp_eq_o,
    input  rsp0_ready_i, rsp1_ready_i,
    output alu_op1_o, alu_op2_o, alu_ctrl_o,
    input  alu_out_i, alu_eq_i
  );

  modport master (
    output req0_valid_i, req0_op1_i, req0_op2_i, req0_ctrl_i,
    output req1_valid_i, req1_op1_i, req1_op2_i, req1_ctrl_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp1_valid_o, rsp_data_o, rsp_eq_o,
    output rsp0_ready_i, rsp1_ready_i,
    input  alu_op1_o, alu_op2_o, alu_ctrl_o,
    output alu_out_i, alu_eq_i
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. An accepted operation is registered, presented to the ALU for
// one EXEC cycle, and the captured result/eq flag is returned on the granted
// requester's response channel.
// Ports:
//   clk_i  - clock, all state on rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - alu_arbiter_if.slave: req0/req1 valid/ready + operands,
//            rsp0/rsp1 valid/ready + shared rsp_data_o/rsp_eq_o,
//            ALU operands out / result in
module alu_arbiter #(
  parameter int unsigned DW = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q;
  logic          last_grant_q;
  logic          grant_q;
  logic [DW-1:0] op1_q;
  logic [DW-1:0] op2_q;
  logic [2:0]    ctrl_q;
  logic [DW-1:0] res_q;
  logic          eq_q;
  logic          rsp0_valid_q;
  logic          rsp1_valid_q;

  logic          grant_d;
  logic          accept;
  logic          rsp_hs;

  // Requester selected in IDLE. A lone valid wins outright; on a tie, or
  // with nothing pending, the requester not granted last is offered ready.
  always_comb begin
    grant_d = ~last_grant_q;
    if (bus.req0_valid_i != bus.req1_valid_i) begin
      grant_d = bus.req1_valid_i;
    end
  end

  assign bus.req0_ready_o = (state_q == IDLE) & ~grant_d;
  assign bus.req1_ready_o = (state_q == IDLE) &  grant_d;

  assign accept = (state_q == IDLE) &
                  (grant_d ? bus.req1_valid_i : bus.req0_valid_i);
  assign rsp_hs = grant_q ? bus.rsp1_ready_i : bus.rsp0_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      ctrl_q       <= 3'b000;
      res_q        <= '0;
      eq_q         <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op1_q        <= grant_d ? bus.req1_op1_i  : bus.req0_op1_i;
            op2_q        <= grant_d ? bus.req1_op2_i  : bus.req0_op2_i;
            ctrl_q       <= grant_d ? bus.req1_ctrl_i : bus.req0_ctrl_i;
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          res_q        <= bus.alu_out_i;
          eq_q         <= bus.alu_eq_i;
          rsp0_valid_q <= ~grant_q;
          rsp1_valid_q <=  grant_q;
          state_q      <= RESP;
        end
        RESP: begin
          // The handshake cycle never doubles as an accept: IDLE follows.
          if (rsp_hs) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_op1_o    = op1_q;
  assign bus.alu_op2_o    = op2_q;
  assign bus.alu_ctrl_o   = ctrl_q;
  assign bus.rsp_data_o   = res_q;
  assign bus.rsp_eq_o     = eq_q;
  assign bus.rsp0_valid_o = rsp0_valid_q;
  assign bus.rsp1_valid_o = rsp1_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Provides a small
// combinational ALU (000 add, 001 sub, others return 0; eq = operands equal)
// and a scoreboard queue of expected responses pushed at acceptance.
module tb_alu_arbiter;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DW(DW)) bus ();

  alu_arbiter #(.DW(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  assign bus.alu_out_i = (bus.alu_ctrl_o == 3'b000) ? bus.alu_op1_o + bus.alu_op2_o :
                         (bus.alu_ctrl_o == 3'b001) ? bus.alu_op1_o - bus.alu_op2_o :
                         '0;
  assign bus.alu_eq_i  = (bus.alu_op1_o == bus.alu_op2_o);

  typedef struct packed {
    logic          gid;
    logic [DW-1:0] data;
    logic          eq;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns once the given requester is accepted at the coming posedge.
  task automatic wait_accept(input bit id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (id ? (bus.req1_valid_i && bus.req1_ready_o)
             : (bus.req0_valid_i && bus.req0_ready_o)) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.req0_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req0_ready: got %0b expected 1", bus.req0_ready_o); end
    checks++; if (bus.req1_ready_o !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %0b expected 0", bus.req1_ready_o); end
    checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", {bus.rsp0_valid_o, bus.rsp1_valid_o}); end
    checks++; if ({bus.rsp_data_o, bus.rsp_eq_o} !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h/%b expected 0/0", bus.rsp_data_o, bus.rsp_eq_o); end
    checks++; if ({bus.alu_op1_o, bus.alu_op2_o, bus.alu_ctrl_o} !== '0) begin errors++; $display("FAIL reset_alu_regs: got %h %h %b expected zeros", bus.alu_op1_o, bus.alu_op2_o, bus.alu_ctrl_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    bit ok;
    exp_t e;
    bus.req0_op1_i = 32'd5; bus.req0_op2_i = 32'd7; bus.req0_ctrl_i = 3'b000;
    bus.req0_valid_i = 1'b1; bus.rsp0_ready_i = 1'b1; bus.rsp1_ready_i = 1'b1;
    wait_accept(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_accept: got timeout expected accept"); end
    checks++; if (bus.req1_ready_o !== 1'b0) begin errors++; $display("FAIL single_req1_ready: got %0b expected 0", bus.req1_ready_o); end
    sb_q.push_back('{gid: 1'b0, data: 32'd12, eq: 1'b0});
    @(negedge clk);
    bus.req0_valid_i = 1'b0;
    #1;
    checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b00) begin errors++; $display("FAIL single_exec_valid: got %b expected 00", {bus.rsp0_valid_o, bus.rsp1_valid_o}); end
    checks++; if ({bus.alu_op1_o, bus.alu_op2_o} !== {32'd5, 32'd7}) begin errors++; $display("FAIL single_exec_ops: got %0d %0d expected 5 7", bus.alu_op1_o, bus.alu_op2_o); end
    @(negedge clk); #1;
    checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b10) begin errors++; $display("FAIL single_rsp_valid: got %b expected 10", {bus.rsp0_valid_o, bus.rsp1_valid_o}); end
    if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL single_sb: got empty scoreboard expected entry"); end
    else begin
      e = sb_q.pop_front();
      checks++; if ({bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o} !== {e.gid, e.data, e.eq}) begin errors++; $display("FAIL single_rsp: got id%0b %0d eq%0b expected id%0b %0d eq%0b", bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o, e.gid, e.data, e.eq); end
    end
    @(negedge clk); #1;
    checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b00) begin errors++; $display("FAIL single_rsp_one_cycle: got %b expected 00", {bus.rsp0_valid_o, bus.rsp1_valid_o}); end
    checks++; if (bus.rsp_data_o !== 32'd12) begin errors++; $display("FAIL single_idle_hold: got %0d expected 12", bus.rsp_data_o); end
    @(negedge clk);
  endtask

  task automatic test_tie();
    int n = 0;
    int last_acc = 0;
    exp_t e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0_op1_i = 32'd3;  bus.req0_op2_i = 32'd3; bus.req0_ctrl_i = 3'b000;
    bus.req1_op1_i = 32'd10; bus.req1_op2_i = 32'd1; bus.req1_ctrl_i = 3'b000;
    bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1;
    bus.rsp0_ready_i = 1'b1; bus.rsp1_ready_i = 1'b1;
    for (int cyc = 0; cyc < 30 && (n < 4 || sb_q.size() > 0); cyc++) begin
      if (n == 4) begin bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0; end
      #1;
      if (bus.rsp0_valid_o || bus.rsp1_valid_o) begin
        if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL tie_sb: got unexpected response expected none"); end
        else begin
          e = sb_q.pop_front();
          checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o} !== {~e.gid, e.gid, e.data, e.eq}) begin errors++; $display("FAIL tie_rsp: got v%b%b %0d eq%0b expected id%0b %0d eq%0b", bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o, e.gid, e.data, e.eq); end
        end
      end
      if (n < 4 && ((bus.req0_valid_i && bus.req0_ready_o) || (bus.req1_valid_i && bus.req1_ready_o))) begin
        checks++; if (bus.req1_ready_o !== n[0]) begin errors++; $display("FAIL tie_grant_order: got %0b expected %0b at grant %0d", bus.req1_ready_o, n[0], n); end
        if (n > 0) begin
          checks++; if (cyc - last_acc != 3) begin errors++; $display("FAIL tie_spacing: got %0d expected 3", cyc - last_acc); end
        end
        if (bus.req1_ready_o) sb_q.push_back('{gid: 1'b1, data: 32'd11, eq: 1'b0});
        else                  sb_q.push_back('{gid: 1'b0, data: 32'd6,  eq: 1'b1});
        last_acc = cyc;
        n++;
      end
      @(negedge clk);
    end
    checks++; if (n != 4 || sb_q.size() != 0) begin errors++; $display("FAIL tie_complete: got %0d grants %0d pending expected 4 grants 0 pending", n, sb_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    exp_t e;
    bus.req0_valid_i = 1'b0; bus.rsp0_ready_i = 1'b1; bus.rsp1_ready_i = 1'b0;
    bus.req1_op1_i = 32'hFFFF_FFFF; bus.req1_op2_i = 32'd1; bus.req1_ctrl_i = 3'b000;
    bus.req1_valid_i = 1'b1;
    wait_accept(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got timeout expected accept"); end
    sb_q.push_back('{gid: 1'b1, data: 32'd0, eq: 1'b0});
    @(negedge clk);
    bus.req1_valid_i = 1'b0;
    bus.req0_op1_i = 32'd1; bus.req0_op2_i = 32'd2; bus.req0_ctrl_i = 3'b000;
    bus.req0_valid_i = 1'b1;
    #1;
    checks++; if (bus.req0_ready_o !== 1'b0) begin errors++; $display("FAIL bp_exec_ready: got %0b expected 0", bus.req0_ready_o); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b01) begin errors++; $display("FAIL bp_hold_valid: got %b expected 01 at cycle %0d", {bus.rsp0_valid_o, bus.rsp1_valid_o}, i); end
      checks++; if ({bus.req0_ready_o, bus.rsp_data_o} !== {1'b0, 32'd0}) begin errors++; $display("FAIL bp_hold_state: got ready%0b data %h expected ready0 data 0", bus.req0_ready_o, bus.rsp_data_o); end
    end
    @(negedge clk);
    bus.rsp1_ready_i = 1'b1;
    #1;
    checks++; if (bus.req0_ready_o !== 1'b0) begin errors++; $display("FAIL bp_hs_ready: got %0b expected 0", bus.req0_ready_o); end
    if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL bp_sb: got empty scoreboard expected entry"); end
    else begin
      e = sb_q.pop_front();
      checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o} !== {~e.gid, e.gid, e.data, e.eq}) begin errors++; $display("FAIL bp_rsp: got v%b%b %h eq%0b expected id%0b %h eq%0b", bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o, e.gid, e.data, e.eq); end
    end
    @(negedge clk);
    bus.rsp1_ready_i = 1'b0;
    #1;
    checks++; if ({bus.rsp1_valid_o, bus.req0_ready_o} !== 2'b01) begin errors++; $display("FAIL bp_idle: got valid%0b ready%0b expected valid0 ready1", bus.rsp1_valid_o, bus.req0_ready_o); end
    sb_q.push_back('{gid: 1'b0, data: 32'd3, eq: 1'b0});
    @(negedge clk);
    bus.req0_valid_i = 1'b0;
    @(negedge clk); #1;
    if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL bp_sb2: got empty scoreboard expected entry"); end
    else begin
      e = sb_q.pop_front();
      checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o} !== {~e.gid, e.gid, e.data, e.eq}) begin errors++; $display("FAIL bp_rsp2: got v%b%b %0d eq%0b expected id%0b %0d eq%0b", bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o, e.gid, e.data, e.eq); end
    end
    @(negedge clk);
  endtask

  task automatic test_unimpl_ctrl();
    bit ok;
    exp_t e;
    bus.req0_op1_i = 32'd9; bus.req0_op2_i = 32'd9; bus.req0_ctrl_i = 3'b010;
    bus.req0_valid_i = 1'b1; bus.rsp0_ready_i = 1'b1;
    wait_accept(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL unimpl_accept: got timeout expected accept"); end
    sb_q.push_back('{gid: 1'b0, data: 32'd0, eq: 1'b1});
    @(negedge clk);
    bus.req0_valid_i = 1'b0;
    #1;
    checks++; if ({bus.alu_ctrl_o, bus.alu_op1_o} !== {3'b010, 32'd9}) begin errors++; $display("FAIL unimpl_alu_in: got ctrl %b op1 %0d expected ctrl 010 op1 9", bus.alu_ctrl_o, bus.alu_op1_o); end
    @(negedge clk); #1;
    if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL unimpl_sb: got empty scoreboard expected entry"); end
    else begin
      e = sb_q.pop_front();
      checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o} !== {~e.gid, e.gid, e.data, e.eq}) begin errors++; $display("FAIL unimpl_rsp: got v%b%b %0d eq%0b expected id%0b %0d eq%0b", bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o, e.gid, e.data, e.eq); end
    end
    @(negedge clk);
  endtask

  task automatic test_stability();
    bit ok;
    exp_t e;
    bus.req0_op1_i = 32'd100; bus.req0_op2_i = 32'd40; bus.req0_ctrl_i = 3'b001;
    bus.req0_valid_i = 1'b1; bus.rsp0_ready_i = 1'b0;
    wait_accept(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stab_accept: got timeout expected accept"); end
    sb_q.push_back('{gid: 1'b0, data: 32'd60, eq: 1'b0});
    @(negedge clk);
    bus.req0_op1_i = 32'hDEAD; bus.req0_op2_i = 32'hBEEF;
    #1;
    checks++; if ({bus.alu_op1_o, bus.alu_op2_o, bus.alu_ctrl_o} !== {32'd100, 32'd40, 3'b001}) begin errors++; $display("FAIL stab_exec_ops: got %0d %0d %b expected 100 40 001", bus.alu_op1_o, bus.alu_op2_o, bus.alu_ctrl_o); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if ({bus.rsp0_valid_o, bus.rsp_data_o, bus.alu_op1_o} !== {1'b1, 32'd60, 32'd100}) begin errors++; $display("FAIL stab_resp_hold: got v%0b data %0d op1 %0d expected v1 data 60 op1 100", bus.rsp0_valid_o, bus.rsp_data_o, bus.alu_op1_o); end
    end
    @(negedge clk);
    bus.rsp0_ready_i = 1'b1;
    #1;
    if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL stab_sb: got empty scoreboard expected entry"); end
    else begin
      e = sb_q.pop_front();
      checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o} !== {~e.gid, e.gid, e.data, e.eq}) begin errors++; $display("FAIL stab_rsp: got v%b%b %0d eq%0b expected id%0b %0d eq%0b", bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o, e.gid, e.data, e.eq); end
    end
    @(negedge clk);
    bus.req0_valid_i = 1'b0;
    #1;
    checks++; if ({bus.rsp0_valid_o, bus.rsp_data_o} !== {1'b0, 32'd60}) begin errors++; $display("FAIL stab_idle_hold: got v%0b data %0d expected v0 data 60", bus.rsp0_valid_o, bus.rsp_data_o); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_t e;
    bus.req0_op1_i = 32'd1; bus.req0_op2_i = 32'd1; bus.req0_ctrl_i = 3'b000;
    bus.req0_valid_i = 1'b1; bus.rsp0_ready_i = 1'b1; bus.rsp1_ready_i = 1'b1;
    wait_accept(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_accept: got timeout expected accept"); end
    @(negedge clk);
    bus.req0_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o} !== '0) begin errors++; $display("FAIL rmid_async_outputs: got v%b%b data %0d eq%0b expected all 0", bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o); end
    checks++; if ({bus.alu_op1_o, bus.req0_ready_o} !== {32'd0, 1'b1}) begin errors++; $display("FAIL rmid_async_state: got op1 %0d ready0 %0b expected op1 0 ready0 1", bus.alu_op1_o, bus.req0_ready_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o} !== 2'b00) begin errors++; $display("FAIL rmid_no_rsp: got %b expected 00 at cycle %0d", {bus.rsp0_valid_o, bus.rsp1_valid_o}, i); end
    end
    @(negedge clk);
    bus.req0_op1_i = 32'd4; bus.req0_op2_i = 32'd4; bus.req0_ctrl_i = 3'b000;
    bus.req1_op1_i = 32'd2; bus.req1_op2_i = 32'd5; bus.req1_ctrl_i = 3'b000;
    bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1;
    #1;
    checks++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b10) begin errors++; $display("FAIL rmid_tie_after_reset: got %b expected 10", {bus.req0_ready_o, bus.req1_ready_o}); end
    sb_q.push_back('{gid: 1'b0, data: 32'd8, eq: 1'b1});
    @(negedge clk);
    bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
    @(negedge clk); #1;
    if (sb_q.size() == 0) begin checks++; errors++; $display("FAIL rmid_sb: got empty scoreboard expected entry"); end
    else begin
      e = sb_q.pop_front();
      checks++; if ({bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o} !== {~e.gid, e.gid, e.data, e.eq}) begin errors++; $display("FAIL rmid_rsp: got v%b%b %0d eq%0b expected id%0b %0d eq%0b", bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp_data_o, bus.rsp_eq_o, e.gid, e.data, e.eq); end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.req0_valid_i = 1'b0; bus.req0_op1_i = '0; bus.req0_op2_i = '0; bus.req0_ctrl_i = 3'b000;
    bus.req1_valid_i = 1'b0; bus.req1_op1_i = '0; bus.req1_op2_i = '0; bus.req1_ctrl_i = 3'b000;
    bus.rsp0_ready_i = 1'b0; bus.rsp1_ready_i = 1'b0;
    test_reset();
    test_single_op();
    test_tie();
    test_backpressure();
    test_unimpl_ctrl();
    test_stability();
    test_reset_mid();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drained: got %0d pending expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
